// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// The optional performance counters (PC_SEQ_PERF_EN) reuse XLEN from here.
package pc_seq_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam int FLUSH_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } pc_seq_state_t;

    // Redirect targets are forced onto an instruction boundary.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] target);
        return {target[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_seq_perf.sv
// Saturating stall-cycle and redirect counters for the PC sequencer.
// Instantiated only when PC_SEQ_PERF_EN is defined.
module pc_seq_perf
    import pc_seq_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            stall_event,
    input  logic            redirect_event,
    output logic [XLEN-1:0] stall_cycles,
    output logic [XLEN-1:0] redirect_count
);

    logic [1:0]            event_vec;
    logic [1:0][XLEN-1:0]  count_vec;

    assign event_vec = {redirect_event, stall_event};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [XLEN-1:0] cnt_reg;

            // Counters stick at all-ones rather than wrapping.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset)
                    cnt_reg <= '0;
                else if (event_vec[gi] && (cnt_reg != '1))
                    cnt_reg <= cnt_reg + XLEN'(1);
            end

            assign count_vec[gi] = cnt_reg;
        end
    endgenerate

    assign stall_cycles   = count_vec[0];
    assign redirect_count = count_vec[1];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: arbitrates jump/branch redirects, stalls and the
// imem handshake onto a registered PC. Optional counters via PC_SEQ_PERF_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] pc,
    output logic            fetch_valid,
    output logic            flush,
    output logic            misaligned,
    output logic [1:0]      state
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [XLEN-1:0] stall_cycles,
    output logic [XLEN-1:0] redirect_count
`endif
);

    pc_seq_state_t          state_reg, state_next;
    logic [XLEN-1:0]        pc_reg, pc_next;
    logic [FLUSH_CNT_W-1:0] cnt_reg, cnt_next;
    logic                   misaligned_reg, misaligned_next;
    logic                   fetch_valid_reg, flush_reg;
    logic [XLEN-1:0]        target;
    logic                   advance;

    assign target  = jump ? jump_target : branch_target;
    assign advance = !stall && fetch_ready;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        cnt_next        = cnt_reg;
        misaligned_next = 1'b0;
        if (state_reg == ST_BOOT) begin
            state_next = ST_RUN;
        end else if (jump || branch_taken) begin
            pc_next         = align_target(target);
            misaligned_next = (target[1:0] != 2'b00);
            cnt_next        = FLUSH_CNT_W'(FLUSH_CYCLES);
            state_next      = ST_FLUSH;
        end else if (state_reg == ST_RUN) begin
            if (stall)
                state_next = ST_HOLD;
            else if (fetch_ready)
                pc_next = pc_reg + XLEN'(INSTR_BYTES);
        end else if (state_reg == ST_HOLD) begin
            // Leaving HOLD spends one edge in RUN before the PC moves again.
            if (!stall)
                state_next = ST_RUN;
        end else begin
            cnt_next = cnt_reg - FLUSH_CNT_W'(1);
            if (advance)
                pc_next = pc_reg + XLEN'(INSTR_BYTES);
            if (cnt_reg == FLUSH_CNT_W'(1))
                state_next = ST_RUN;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_BOOT;
            pc_reg          <= RESET_VECTOR;
            cnt_reg         <= '0;
            misaligned_reg  <= 1'b0;
            fetch_valid_reg <= 1'b0;
            flush_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            cnt_reg         <= cnt_next;
            misaligned_reg  <= misaligned_next;
            fetch_valid_reg <= (state_next == ST_RUN) || (state_next == ST_FLUSH);
            flush_reg       <= (state_next == ST_FLUSH);
        end
    end

    assign pc          = pc_reg;
    assign fetch_valid = fetch_valid_reg;
    assign flush       = flush_reg;
    assign misaligned  = misaligned_reg;
    assign state       = state_reg;

`ifdef PC_SEQ_PERF_EN
    logic stall_event, redirect_event;

    assign stall_event    = (state_reg == ST_HOLD) || (fetch_valid_reg && !fetch_ready);
    assign redirect_event = (state_reg != ST_BOOT) && (jump || branch_taken);

    pc_seq_perf u_perf (
        .clock          (clock),
        .reset          (reset),
        .stall_event    (stall_event),
        .redirect_event (redirect_event),
        .stall_cycles   (stall_cycles),
        .redirect_count (redirect_count)
    );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer plus hand sequences for async reset
// and PC wrap-around; counter checks compile in with PC_SEQ_PERF_EN.
module tb_pc_sequencer;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        rdy;
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        mis;
        logic [1:0]  st;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, fetch_ready = 1'b0;
    logic [31:0] branch_target = '0, jump_target = '0;
    logic [31:0] pc;
    logic        fetch_valid, flush, misaligned;
    logic [1:0]  state;

    logic        w_reset = 1'b0;
    logic        w_zero  = 1'b0;
    logic        w_one   = 1'b1;
    logic [31:0] w_tgt   = '0;
    logic [31:0] w_pc;
    logic        w_valid, w_flush, w_mis;
    logic [1:0]  w_state;

`ifdef PC_SEQ_PERF_EN
    logic [31:0] stall_cycles, redirect_count, w_sc, w_rc;
`endif

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[0:40];

    always #5 clock = ~clock;

    pc_sequencer dut (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .fetch_ready(fetch_ready),
        .pc(pc), .fetch_valid(fetch_valid), .flush(flush),
        .misaligned(misaligned), .state(state)
`ifdef PC_SEQ_PERF_EN
        , .stall_cycles(stall_cycles), .redirect_count(redirect_count)
`endif
    );

    pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_wrap (
        .clock(clock), .reset(w_reset), .stall(w_zero),
        .branch_taken(w_zero), .branch_target(w_tgt),
        .jump(w_zero), .jump_target(w_tgt), .fetch_ready(w_one),
        .pc(w_pc), .fetch_valid(w_valid), .flush(w_flush),
        .misaligned(w_mis), .state(w_state)
`ifdef PC_SEQ_PERF_EN
        , .stall_cycles(w_sc), .redirect_count(w_rc)
`endif
    );

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt, input logic r,
                                input logic [31:0] epc, input logic ev, input logic ef,
                                input logic em, input logic [1:0] est);
        vec_t v;
        v.stall = s; v.br = b; v.bt = bt; v.jmp = j; v.jt = jt; v.rdy = r;
        v.pc = epc; v.valid = ev; v.flush = ef; v.mis = em; v.st = est;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] a_pc, input logic a_v,
                         input logic a_f, input logic a_m, input logic [1:0] a_s,
                         input logic [31:0] e_pc, input logic e_v, input logic e_f,
                         input logic e_m, input logic [1:0] e_s);
        n_vec++;
        if (a_pc !== e_pc || a_v !== e_v || a_f !== e_f || a_m !== e_m || a_s !== e_s) begin
            n_err++;
            $display("FAIL %s: got pc=%h valid=%b flush=%b mis=%b state=%0d, want pc=%h valid=%b flush=%b mis=%b state=%0d",
                     name, a_pc, a_v, a_f, a_m, a_s, e_pc, e_v, e_f, e_m, e_s);
        end else begin
            $display("ok   %s: pc=%h valid=%b flush=%b mis=%b state=%0d", name, a_pc, a_v, a_f, a_m, a_s);
        end
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            stall = tbl[i].stall; branch_taken = tbl[i].br; branch_target = tbl[i].bt;
            jump = tbl[i].jmp; jump_target = tbl[i].jt; fetch_ready = tbl[i].rdy;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), pc, fetch_valid, flush, misaligned, state,
                  tbl[i].pc, tbl[i].valid, tbl[i].flush, tbl[i].mis, tbl[i].st);
        end
    endtask

    initial begin
        //           stall br bt           jmp jt           rdy  pc          v  f  m  st
        tbl[0]  = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h0,     1, 0, 0, 1);
        tbl[1]  = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h4,     1, 0, 0, 1);
        tbl[2]  = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h8,     1, 0, 0, 1);
        tbl[3]  = mk(0, 1, 32'h100,   0, 32'h0,     1, 32'h100,   1, 1, 0, 3);
        tbl[4]  = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h104,   1, 1, 0, 3);
        tbl[5]  = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h108,   1, 0, 0, 1);
        tbl[6]  = mk(0, 1, 32'h300,   1, 32'h200,   1, 32'h200,   1, 1, 0, 3);
        tbl[7]  = mk(0, 0, 32'h0,     1, 32'h203,   1, 32'h200,   1, 1, 1, 3);
        tbl[8]  = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h204,   1, 1, 0, 3);
        tbl[9]  = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h208,   1, 0, 0, 1);
        tbl[10] = mk(0, 0, 32'h0,     1, 32'h20,    1, 32'h20,    1, 1, 0, 3);
        tbl[11] = mk(0, 0, 32'h0,     0, 32'h0,     0, 32'h20,    1, 1, 0, 3);
        tbl[12] = mk(0, 0, 32'h0,     0, 32'h0,     0, 32'h20,    1, 0, 0, 1);
        tbl[13] = mk(1, 0, 32'h0,     0, 32'h0,     1, 32'h20,    0, 0, 0, 2);
        tbl[14] = mk(1, 0, 32'h0,     0, 32'h0,     1, 32'h20,    0, 0, 0, 2);
        tbl[15] = mk(1, 0, 32'h0,     0, 32'h0,     1, 32'h20,    0, 0, 0, 2);
        tbl[16] = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h20,    1, 0, 0, 1);
        tbl[17] = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h24,    1, 0, 0, 1);
        tbl[18] = mk(0, 0, 32'h0,     0, 32'h0,     0, 32'h24,    1, 0, 0, 1);
        tbl[19] = mk(0, 0, 32'h0,     0, 32'h0,     0, 32'h24,    1, 0, 0, 1);
        tbl[20] = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h28,    1, 0, 0, 1);
        tbl[21] = mk(1, 1, 32'h40,    0, 32'h0,     1, 32'h40,    1, 1, 0, 3);
        tbl[22] = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h44,    1, 1, 0, 3);
        tbl[23] = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h48,    1, 0, 0, 1);
        tbl[24] = mk(1, 0, 32'h0,     0, 32'h0,     1, 32'h48,    0, 0, 0, 2);
        tbl[25] = mk(1, 1, 32'h81,    0, 32'h0,     1, 32'h80,    1, 1, 1, 3);
        tbl[26] = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h84,    1, 1, 0, 3);
        tbl[27] = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h88,    1, 0, 0, 1);
        tbl[28] = mk(0, 0, 32'h0,     1, 32'h300,   1, 32'h300,   1, 1, 0, 3);
        // after the mid-flush reset: BOOT again, then a counter workload
        tbl[29] = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h0,     1, 0, 0, 1);
        tbl[30] = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h4,     1, 0, 0, 1);
        tbl[31] = mk(0, 0, 32'h0,     1, 32'h40,    1, 32'h40,    1, 1, 0, 3);
        tbl[32] = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h44,    1, 1, 0, 3);
        tbl[33] = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h48,    1, 0, 0, 1);
        tbl[34] = mk(1, 0, 32'h0,     0, 32'h0,     1, 32'h48,    0, 0, 0, 2);
        tbl[35] = mk(1, 0, 32'h0,     0, 32'h0,     1, 32'h48,    0, 0, 0, 2);
        tbl[36] = mk(1, 0, 32'h0,     0, 32'h0,     1, 32'h48,    0, 0, 0, 2);
        tbl[37] = mk(0, 0, 32'h0,     0, 32'h0,     1, 32'h48,    1, 0, 0, 1);
        tbl[38] = mk(0, 0, 32'h0,     0, 32'h0,     0, 32'h48,    1, 0, 0, 1);
        tbl[39] = mk(0, 0, 32'h0,     0, 32'h0,     0, 32'h48,    1, 0, 0, 1);
        tbl[40] = mk(0, 1, 32'h500,   0, 32'h0,     1, 32'h500,   1, 1, 0, 3);

        // reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", pc, fetch_valid, flush, misaligned, state, 32'h0, 0, 0, 0, 0);
        check("wrap_reset_state", w_pc, w_valid, w_flush, w_mis, w_state, 32'hFFFF_FFF8, 0, 0, 0, 0);
        #2 reset = 1'b1;

        run_vectors(0, 28);

        // asynchronous reset in the middle of FLUSH
        #3 reset = 1'b0;
        #1;
        check("async_reset_midflush", pc, fetch_valid, flush, misaligned, state, 32'h0, 0, 0, 0, 0);
        #1 reset = 1'b1;

        run_vectors(29, 40);

`ifdef PC_SEQ_PERF_EN
        n_vec++;
        if (redirect_count !== 32'd2 || stall_cycles !== 32'd5) begin
            n_err++;
            $display("FAIL perf_counters: got redirects=%0d stalls=%0d, want redirects=2 stalls=5",
                     redirect_count, stall_cycles);
        end else begin
            $display("ok   perf_counters: redirects=%0d stalls=%0d", redirect_count, stall_cycles);
        end
`endif

        // wrap-around from a high reset vector
        #2 w_reset = 1'b1;
        @(posedge clock); #1;
        check("wrap_boot", w_pc, w_valid, w_flush, w_mis, w_state, 32'hFFFF_FFF8, 1, 0, 0, 1);
        @(posedge clock); #1;
        check("wrap_fffc", w_pc, w_valid, w_flush, w_mis, w_state, 32'hFFFF_FFFC, 1, 0, 0, 1);
        @(posedge clock); #1;
        check("wrap_zero", w_pc, w_valid, w_flush, w_mis, w_state, 32'h0000_0000, 1, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
